// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types for the cache->RAM path.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM handshake state reported back by the memory
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/arb_timeout_counter.sv
// Grant watchdog for cache_mem_arbiter.
//   CLK, nRST : clock, async active-low reset
//   clear     : hold count at zero (asserted while no grant is active)
//   enable    : one more grant cycle elapsed without RAM ACCESS
//   expired   : combinational pulse on the cycle whose increment reaches
//               TIMEOUT_CYCLES
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count before increment equals LIMIT-1 -> this cycle makes it LIMIT.
  assign expired = enable && (cnt == LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache (read-only) and dcache (read/write) word requests onto a
// single-ported RAM. One word per grant; wait drops for exactly the cycle
// the RAM reports ACCESS.
//   CLK, nRST                        : clock, async active-low reset
//   iREN, iaddr / iwait, iload       : icache request / response
//   dREN, dWEN, daddr, dstore        : dcache request
//   dwait, dload                     : dcache response
//   ramREN, ramWEN, ramaddr, ramstore: RAM command (combinational)
//   ramload, ramstate                : RAM response
//   timeout                          : sticky, a grant waited TIMEOUT_CYCLES
// Build option: ARB_RR_EN selects round-robin between simultaneous requesters;
// without it dcache has fixed priority.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              timeout
);
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t DGRANT = 2'd1;
  localparam arb_state_t IGRANT = 2'd2;

  arb_state_t state, nstate;
  logic d_req, access, cur_req, expired, cnt_en;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == ACCESS);

  always_comb begin
    cur_req = 1'b0;
    if (state == DGRANT) cur_req = d_req;
    if (state == IGRANT) cur_req = iREN;
  end

  // Aborted grants leave this cycle anyway, so only live, unserved grants count.
  assign cnt_en = cur_req && !access;

  arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .enable  (cnt_en),
    .expired (expired)
  );

`ifdef ARB_RR_EN
  logic last_d;  // 1 = dcache completed most recently, 0 = icache
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                        last_d <= 1'b0;
    else if (state == DGRANT && d_req && access)      last_d <= 1'b1;
    else if (state == IGRANT && iREN && access)       last_d <= 1'b0;
  end
`endif

  always_comb begin
    nstate   = state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
`ifdef ARB_RR_EN
        if (d_req && iREN) nstate = last_d ? IGRANT : DGRANT;
        else if (d_req)    nstate = DGRANT;
        else if (iREN)     nstate = IGRANT;
`else
        if (d_req)         nstate = DGRANT;
        else if (iREN)     nstate = IGRANT;
`endif
      end
      DGRANT: begin
        if (!d_req) nstate = IDLE;  // client withdrew: enables stay gated off
        else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (access) begin
            dwait  = 1'b0;
            dload  = dWEN ? '0 : ramload;
            nstate = IDLE;
          end else if (expired) begin
            nstate = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) nstate = IDLE;
        else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (access) begin
            iwait  = 1'b0;
            iload  = ramload;
            nstate = IDLE;
          end else if (expired) begin
            nstate = IDLE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      timeout <= 1'b0;
    end else begin
      state <= nstate;
      if (expired) timeout <= 1'b1;
    end
  end
endmodule
